mux_rr_nto1: RTL and testbench
==============================

# mux_rr_nto1

Parametrised registered N-to-1 channel multiplexer: the sequential successor of the 8:1 combinational mux. It merges N valid/ready input channels onto one output stream through a single output register. It has two modes: fixed select (legacy mux behaviour) and round-robin arbitration across all requesting channels. It sits between per-channel producers and a single shared downstream consumer.

## Interface
- N, 8, number of input channels (2..16)
- W, 8, data width per channel (1..64)
- SELW, derived = max(1, clog2(N)), width of select/channel index (localparam, not overridable)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_data  in  N*W  channel i occupies bits [i*W +: W]
- in_valid  in  N  channel i has a word
- in_ready  out  N  channel i word accepted this cycle (one-hot or zero)
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SELW  channel index used in fixed mode
- out_data  out  W  registered data
- out_chan  out  SELW  index of the channel that supplied out_data
- out_valid  out  1  output register holds a word
- out_ready  in  1  downstream accepts out_data

## Operation
- Decided interface rule: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset state: out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=0, in_ready=0.
- Load enable: ld = !out_valid | out_ready.
- Eligibility and grant, combinational on current-cycle inputs:
  - Fixed mode: channel sel is eligible only if sel < N and in_valid[sel]=1. sel >= N grants nothing.
  - Round-robin mode: search indices ptr, ptr+1, … modulo N. Grant the first with in_valid=1.
- Grant g exists and ld=1: in_ready[g]=1 (all other bits 0). Next edge: out_data <= in_data[g], out_chan <= g, out_valid <= 1, ptr <= (g == N-1) ? 0 : g+1.
- Pointer update applies to grants in both modes. Switching fixed -> round-robin resumes after the last granted channel.
- No grant and ld=1: out_valid <= 0 at the next edge. out_data and out_chan hold their last value.
- ld=0 (out_valid=1, out_ready=0): output register, ptr and out_chan hold. in_ready=0.
- in_ready may depend combinationally on in_valid, mode, sel and out_ready. Producers must not make in_valid depend on in_ready.
- mode and sel are sampled each cycle; a change affects the grant in the same cycle. No in-flight word is dropped or duplicated.
- Each accepted input word appears at the output exactly once, in per-channel order.

## Timing
- Latency: input word accepted at edge k is visible on out_data/out_valid after edge k (1 cycle).
- Throughput: 1 word/cycle when out_ready held high and some channel is eligible.
- Back-to-back: out_valid=1 with out_ready=1 and a grant means the register reloads the same edge. There is no bubble.
- Round-robin fairness: with all N channels valid continuously, each channel is granted exactly once every N consecutive grants.
- Single requester: with one channel valid continuously in round-robin mode, it is granted every cycle (pointer wrap must not insert gaps).
- Wrap: grant at N-1 sets ptr=0. Grant at ptr-1 (mod N) is searched last.
- Reset mid-stream: rst=1 at an edge clears out_valid regardless of out_ready. The held word is discarded. in_ready=0 during any cycle with rst=1.
- Simultaneous rst and grant: reset wins; no word is accepted (in_ready forced 0).

## Test plan
- Fixed-mode sweep (N=8, W=8, out_ready=1): in_valid=8'hFF, channel i data = 8'h10+i, sel stepped 0..7 one per cycle -> out_data 8'h10..8'h17 one cycle later each, out_chan matches sel, in_ready one-hot = 1<<sel.
- Round-robin all-valid: mode=1, in_valid=8'hFF held 16 cycles -> out_chan sequence 0,1,…,7,0,…,7. out_valid continuously 1 after first edge.
- Round-robin sparse/wrap: in_valid=8'b1000_0010 with ptr=0 -> grants alternate 1,7,1,7. ptr after grant 7 is 0.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data/out_chan stable, in_ready=0. Release -> next grant is the channel following the held out_chan.
- Fixed-mode idle/out-of-range: N=6, sel=3'd7, in_valid all 1 -> no in_ready, out_valid drops to 0 after draining current word.
- Reset mid-stream: assert rst for 1 cycle while out_valid=1, out_ready=0 -> next cycle out_valid=0, out_chan=0, out_data=0. With in_valid=8'hFF, the first post-reset round-robin grant is channel 0.

Source files
------------

// File: rtl/mux_rr_nto1.sv
// mux_rr_nto1: registered N-to-1 valid/ready channel multiplexer.
// Merges N producer channels into one output register, either from a fixed
// select index or by round-robin arbitration over all requesting channels.
module mux_rr_nto1 #(
    parameter  int N    = 8,
    parameter  int W    = 8,
    localparam int SELW = (N > 2) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_chan,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [W-1:0]    r_data;
    logic [SELW-1:0] r_chan;
    logic            r_valid;
    logic [SELW-1:0] r_ptr;

    logic            w_ld;
    logic            w_gnt_vld;
    logic [SELW-1:0] w_gnt;
    logic [W-1:0]    w_gnt_data;
    logic            w_fire;
    logic            w_hi_hit;
    logic [SELW-1:0] w_hi;
    logic            w_lo_hit;
    logic [SELW-1:0] w_lo;

    // The output register can take a new word when empty or being drained.
    assign w_ld   = !r_valid || out_ready;
    // Reset blocks acceptance so no word is taken on a reset edge.
    assign w_fire = w_ld && w_gnt_vld && !rst;

    // Round-robin search split in two: lowest requester at or above the
    // pointer wins; otherwise wrap around to the lowest requester overall.
    always_comb begin
        w_hi_hit = 1'b0;
        w_hi     = '0;
        w_lo_hit = 1'b0;
        w_lo     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                w_lo_hit = 1'b1;
                w_lo     = SELW'(i);
            end
            if (in_valid[i] && (i >= int'(r_ptr))) begin
                w_hi_hit = 1'b1;
                w_hi     = SELW'(i);
            end
        end
    end

    // Grant selection: fixed index (out-of-range grants nothing) or round-robin.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if ((int'(sel) == i) && in_valid[i]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = SELW'(i);
                end
            end
        end else if (w_hi_hit) begin
            w_gnt_vld = 1'b1;
            w_gnt     = w_hi;
        end else if (w_lo_hit) begin
            w_gnt_vld = 1'b1;
            w_gnt     = w_lo;
        end
    end

    // Data mux for the granted channel and the one-hot accept back to producers.
    always_comb begin
        w_gnt_data = '0;
        in_ready   = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(w_gnt) == i) begin
                w_gnt_data  = in_data[i*W +: W];
                in_ready[i] = w_fire;
            end
        end
    end

    // Output register and round-robin pointer; pointer advances past every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_chan  <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else if (w_ld) begin
            if (w_gnt_vld) begin
                r_data  <= w_gnt_data;
                r_chan  <= w_gnt;
                r_valid <= 1'b1;
                r_ptr   <= (int'(w_gnt) == N - 1) ? '0 : w_gnt + 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_chan  = r_chan;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_rr_nto1.sv
// tb_mux_rr_nto1: directed plus random checks of two mux instances (N=8, N=6)
// against a behavioural model of the grant rules, with explicit sequence checks.
module tb_mux_rr_nto1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] t_valid [2];
    logic       t_mode  [2];
    logic [2:0] t_sel   [2];
    logic       t_ordy  [2];
    logic [7:0] t_data  [2][8];

    logic [63:0] a_data;
    logic [47:0] b_data;
    logic [7:0]  a_rdy, a_od;
    logic [5:0]  b_rdy;
    logic [7:0]  b_od;
    logic [2:0]  a_oc, b_oc;
    logic        a_ov, b_ov;

    // Pack per-channel stimulus words into the flat data buses.
    always_comb begin
        a_data = '0;
        b_data = '0;
        for (int i = 0; i < 8; i++) a_data[i*8 +: 8] = t_data[0][i];
        for (int i = 0; i < 6; i++) b_data[i*8 +: 8] = t_data[1][i];
    end

    mux_rr_nto1 #(.N(8), .W(8)) u_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(t_valid[0]),
        .in_ready(a_rdy), .mode(t_mode[0]), .sel(t_sel[0]), .out_data(a_od),
        .out_chan(a_oc), .out_valid(a_ov), .out_ready(t_ordy[0])
    );

    mux_rr_nto1 #(.N(6), .W(8)) u_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(t_valid[1][5:0]),
        .in_ready(b_rdy), .mode(t_mode[1]), .sel(t_sel[1]), .out_data(b_od),
        .out_chan(b_oc), .out_valid(b_ov), .out_ready(t_ordy[1])
    );

    int nvec = 0;
    int nerr = 0;

    // Reference state: output register contents and round-robin pointer.
    int       m_ptr [2];
    logic     m_ov  [2];
    logic [7:0] m_od [2];
    int       m_oc  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational and registered outputs mid-cycle, then
    // advance the model across the edge.
    task automatic step();
        int       n, g, c, nptr, noc;
        logic     ld, nov;
        logic [7:0] er, nod, ordy, oov;
        logic [7:0] ood;
        logic [2:0] ooc;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n  = (u == 0) ? 8 : 6;
            g  = -1;
            ld = !m_ov[u] || t_ordy[u];
            if (!t_mode[u]) begin
                if (int'(t_sel[u]) < n && t_valid[u][t_sel[u]]) g = int'(t_sel[u]);
            end else begin
                for (int k = 0; k < n; k++) begin
                    c = (m_ptr[u] + k) % n;
                    if (g < 0 && t_valid[u][c]) g = c;
                end
            end
            er = (rst || !ld || g < 0) ? 8'h00 : 8'(1 << g);
            if (u == 0) begin
                ordy = a_rdy; oov = {7'b0, a_ov}; ood = a_od; ooc = a_oc;
            end else begin
                ordy = {2'b0, b_rdy}; oov = {7'b0, b_ov}; ood = b_od; ooc = b_oc;
            end
            chk($sformatf("u%0d in_ready", u), 32'(ordy), 32'(er));
            chk($sformatf("u%0d out_valid", u), 32'(oov), 32'(m_ov[u]));
            chk($sformatf("u%0d out_data", u), 32'(ood), 32'(m_od[u]));
            chk($sformatf("u%0d out_chan", u), 32'(ooc), 32'(m_oc[u]));
            nptr = m_ptr[u]; nov = m_ov[u]; nod = m_od[u]; noc = m_oc[u];
            if (rst) begin
                nptr = 0; nov = 1'b0; nod = 8'h00; noc = 0;
            end else if (ld) begin
                if (g >= 0) begin
                    nod = t_data[u][g]; noc = g; nov = 1'b1; nptr = (g + 1) % n;
                end else begin
                    nov = 1'b0;
                end
            end
            m_ptr[u] = nptr; m_ov[u] = nov; m_od[u] = nod; m_oc[u] = noc;
        end
        @(posedge clk);
        #1;
    endtask

    int exp_seq [4] = '{1, 7, 1, 7};

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            t_valid[u] = 8'h00; t_mode[u] = 1'b0; t_sel[u] = 3'd0; t_ordy[u] = 1'b1;
            for (int i = 0; i < 8; i++) t_data[u][i] = 8'h00;
            m_ptr[u] = 0; m_ov[u] = 1'b0; m_od[u] = 8'h00; m_oc[u] = 0;
        end
        @(posedge clk);
        #1;
        // Reset state, with requests present but reset still high.
        t_valid[0] = 8'hFF; t_valid[1] = 8'h3F;
        step();
        rst = 1'b0;

        // Fixed-mode sweep on the 8-channel instance.
        for (int i = 0; i < 8; i++) t_data[0][i] = 8'h10 + 8'(i);
        for (int s = 0; s < 8; s++) begin
            t_sel[0] = 3'(s);
            step();
            chk("sweep data", 32'(a_od), 32'(8'h10 + 8'(s)));
            chk("sweep chan", 32'(a_oc), 32'(s));
        end

        // Round-robin with all channels requesting.
        t_mode[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("rr chan", 32'(a_oc), 32'(i % 8));
            chk("rr valid", 32'(a_ov), 32'd1);
        end

        // Sparse requesters exercise the wrap from channel 7 to channel 1.
        t_valid[0] = 8'b1000_0010;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sparse chan", 32'(a_oc), 32'(exp_seq[i]));
        end

        // Backpressure holds the register; release resumes after held channel.
        t_valid[0] = 8'hFF;
        t_ordy[0]  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold chan", 32'(a_oc), 32'd7);
        end
        t_ordy[0] = 1'b1;
        step();
        chk("release chan", 32'(a_oc), 32'd0);

        // Out-of-range fixed select on the 6-channel instance drains to idle.
        t_mode[1] = 1'b0; t_sel[1] = 3'd2; t_valid[1] = 8'h3F; t_ordy[1] = 1'b1;
        step();
        chk("oor load", 32'(b_oc), 32'd2);
        t_sel[1] = 3'd7;
        step();
        chk("oor idle", 32'(b_ov), 32'd0);
        step();

        // Reset mid-stream while the held word is stalled.
        t_ordy[0] = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        t_ordy[0] = 1'b1;
        chk("post-rst valid", 32'(a_ov), 32'd0);
        chk("post-rst chan", 32'(a_oc), 32'd0);
        chk("post-rst data", 32'(a_od), 32'd0);
        step();
        chk("post-rst grant", 32'(a_oc), 32'd0);

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            for (int u = 0; u < 2; u++) begin
                t_valid[u] = 8'($urandom) & ((u == 0) ? 8'hFF : 8'h3F);
                t_mode[u]  = ($urandom_range(0, 3) != 0);
                t_sel[u]   = 3'($urandom_range(0, 7));
                t_ordy[u]  = ($urandom_range(0, 3) != 0);
                for (int k = 0; k < 8; k++) t_data[u][k] = 8'($urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
